lpif_txrx_param_master: RTL

Parametrised LPIF-over-AIB master transport with configurable channel count, channel width and data width. It packs the LPIF downstream flit fields into NUM_CHAN PHY channel words, inserting a per-word strobe bit and marker bit, and sequences TX bring-up with a programmable delay. On receive it waits for strobe alignment across all channels before unpacking the upstream flit. It sits between the LPIF adapter and the AIB PHY channel array.

---
 rtl/lpif_txrx_param_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lpif_txrx_param_master.sv
// LPIF-over-AIB master transport: packs LPIF flits into NUM_CHAN strobed PHY words and aligns/unpacks on receive.
// Optional build macro LPIF_TXRX_RX_REALIGN_EN: strobe loss while active forces a fresh RX alignment.
module lpif_txrx_param_master #(
    parameter int NUM_CHAN   = 8,
    parameter int CHAN_WIDTH = 80,
    parameter int DATA_WIDTH = 512
) (
    input  logic                             clk_wr,
    input  logic                             rst_wr_n,
    input  logic                             tx_online,
    input  logic                             rx_online,
    input  logic [15:0]                      delay_x_value,
    input  logic [15:0]                      delay_y_value,
    input  logic [15:0]                      delay_z_value,
    output logic [NUM_CHAN*CHAN_WIDTH-1:0]   tx_phy,
    input  logic [NUM_CHAN*CHAN_WIDTH-1:0]   rx_phy,
    input  logic [3:0]                       dstrm_state,
    input  logic [1:0]                       dstrm_protid,
    input  logic [DATA_WIDTH-1:0]            dstrm_data,
    input  logic                             dstrm_dvalid,
    input  logic [15:0]                      dstrm_crc,
    input  logic                             dstrm_crc_valid,
    input  logic                             dstrm_valid,
    output logic [3:0]                       ustrm_state,
    output logic [1:0]                       ustrm_protid,
    output logic [DATA_WIDTH-1:0]            ustrm_data,
    output logic                             ustrm_dvalid,
    output logic [15:0]                      ustrm_crc,
    output logic                             ustrm_crc_valid,
    output logic                             ustrm_valid,
    output logic                             tx_online_delay,
    output logic                             rx_online_delay,
    output logic [31:0]                      debug_status
);

    localparam int PKT_W = DATA_WIDTH + 25;
    localparam int PAY_W = CHAN_WIDTH - 2;
    localparam int TOT_W = NUM_CHAN * PAY_W;

    if (TOT_W < PKT_W) begin : g_size_chk
        $error("lpif_txrx_param_master: NUM_CHAN*(CHAN_WIDTH-2) too small for packet");
    end

    typedef enum logic [1:0] {T_IDLE = 2'd0, T_DELAY = 2'd1, T_ACTIVE = 2'd2} tx_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_DELAY = 2'd1, R_ALIGN = 2'd2, R_ACTIVE = 2'd3} rx_state_t;

    tx_state_t        tx_state;
    rx_state_t        rx_state;
    logic [15:0]      tx_cnt;
    logic [15:0]      rx_cnt;
    logic [7:0]       rx_err_cnt;
    logic [PKT_W-1:0] pkt_q;
    logic [TOT_W-1:0] pkt_pad;
    logic [PKT_W-1:0] rx_pkt;
    logic [PKT_W-1:0] rx_pkt_q;
    logic [NUM_CHAN-1:0] rx_stb;
    logic [NUM_CHAN-1:0] rx_stb_q;
    logic             all_stb;

    assign pkt_pad = TOT_W'(pkt_q);
    assign all_stb = &rx_stb_q;

    always_comb begin
        tx_phy = '0;
        if (tx_state == T_ACTIVE) begin
            for (int unsigned c = 0; c < NUM_CHAN; c++) begin
                tx_phy[c*CHAN_WIDTH +: CHAN_WIDTH] = {2'b11, pkt_pad[c*PAY_W +: PAY_W]};
            end
        end
    end

    // Only payload bits that map onto the packet and the strobes are captured; markers are ignored.
    always_comb begin
        rx_pkt = '0;
        rx_stb = '0;
        for (int unsigned b = 0; b < PKT_W; b++) begin
            rx_pkt[b] = rx_phy[(b / PAY_W) * CHAN_WIDTH + (b % PAY_W)];
        end
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            rx_stb[c] = rx_phy[c*CHAN_WIDTH + CHAN_WIDTH - 2];
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            pkt_q    <= '0;
        end else begin
            pkt_q <= {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                      dstrm_protid, dstrm_state, dstrm_data};
            if (!tx_online) begin
                tx_state <= T_IDLE;
                tx_cnt   <= '0;
            end else begin
                case (tx_state)
                    T_IDLE: begin
                        tx_state <= T_DELAY;
                        tx_cnt   <= '0;
                    end
                    T_DELAY: begin
                        if (tx_cnt == delay_x_value) begin
                            tx_state <= T_ACTIVE;
                            tx_cnt   <= '0;
                        end else begin
                            tx_cnt <= tx_cnt + 16'd1;
                        end
                    end
                    T_ACTIVE: tx_state <= T_ACTIVE;
                    default:  tx_state <= T_IDLE;
                endcase
            end
        end
    end

    // Strobe checks use the registered word so a bad word is still presented before the state reacts.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_err_cnt <= '0;
            rx_pkt_q   <= '0;
            rx_stb_q   <= '0;
        end else begin
            rx_pkt_q <= rx_pkt;
            rx_stb_q <= rx_stb;
            if (!rx_online) begin
                rx_state <= R_IDLE;
                rx_cnt   <= '0;
            end else begin
                case (rx_state)
                    R_IDLE: begin
                        rx_state <= R_DELAY;
                        rx_cnt   <= '0;
                    end
                    R_DELAY: begin
                        if (rx_cnt == delay_y_value) begin
                            rx_state <= R_ALIGN;
                            rx_cnt   <= '0;
                        end else begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end
                    end
                    R_ALIGN: begin
                        if (rx_cnt == delay_z_value) begin
                            rx_state <= R_ACTIVE;
                            rx_cnt   <= '0;
                        end else if (all_stb) begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end else begin
                            rx_cnt <= '0;
                        end
                    end
                    R_ACTIVE: begin
                        if (!all_stb) begin
                            if (rx_err_cnt != 8'hFF) begin
                                rx_err_cnt <= rx_err_cnt + 8'd1;
                            end
`ifdef LPIF_TXRX_RX_REALIGN_EN
                            rx_state <= R_ALIGN;
                            rx_cnt   <= '0;
`endif
                        end
                    end
                    default: rx_state <= R_IDLE;
                endcase
            end
        end
    end

    assign tx_online_delay = (tx_state == T_ACTIVE);
    assign rx_online_delay = (rx_state == R_ACTIVE);

    assign {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
            ustrm_protid, ustrm_state, ustrm_data} = rx_online_delay ? rx_pkt_q : '0;

    assign debug_status = {rx_err_cnt, 4'h0, tx_state, rx_state,
                           tx_online_delay, rx_online_delay, 14'h0};

endmodule
